// File: rtl/sap_control_unit.sv
// -----------------------------------------------------------------------------
// sap_control_unit
//
// Microcoded sequencer for the 8-bit SAP datapath. A T-state step counter walks
// through the common fetch (T0, T1) and the per-opcode execute steps (T2..T4),
// and the current (step, opcode, latched flags) tuple is decoded into the
// control word that steers the shared bus. The unit also owns the flags
// register so that JC/JZ see flags that were latched by an earlier ADD/SUB,
// not the live ALU outputs.
//
// Parameters:
//   EARLY_END  1: return to T0 right after an opcode's last active step
//              0: every instruction runs T0..T4; unused steps emit a zero word
//
// Ports:
//   clk               system clock, rising-edge active
//   rst               asynchronous, active-low reset
//   opcode[3:0]       IR[7:4]
//   zf, cf            live ALU zero / carry flags
//   co ce j mi ro ri ii io ai ao bi eo su oi fi
//                     datapath control strobes (forced low while rst is low)
//   hlt               halted; gates the clock enable of the rest of the CPU
//   step[2:0]         current T-state 0..4 (debug)
//   zf_q, cf_q        latched zero / carry flags
// -----------------------------------------------------------------------------
module sap_control_unit #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zf,
    input  logic       cf,
    output logic       co,
    output logic       ce,
    output logic       j,
    output logic       mi,
    output logic       ro,
    output logic       ri,
    output logic       ii,
    output logic       io,
    output logic       ai,
    output logic       ao,
    output logic       bi,
    output logic       eo,
    output logic       su,
    output logic       oi,
    output logic       fi,
    output logic       hlt,
    output logic [2:0] step,
    output logic       zf_q,
    output logic       cf_q
);

    // S_HALT is a sixth sequencer state rather than a separate flag, so the
    // frozen-at-T2 behaviour falls out of the state machine itself.
    typedef enum logic [2:0] {
        S_T0   = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef struct packed {
        logic co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, eo, su, oi, fi, hlt;
    } ctrl_t;

    state_t r_state;
    state_t w_state_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;
    logic   w_last;
    logic   w_is_nop;
    logic   r_zf;
    logic   r_cf;

    // Opcodes 9..D have no execute steps, exactly like NOP.
    assign w_is_nop = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                                       OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT});

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values; combinational blocks below use blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_T0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Microcode decode and next-state
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        w_ctrl       = '0;
        w_last       = 1'b0;
        w_state_next = r_state;

        case (r_state)
            S_T0: begin
                w_ctrl.co = 1'b1;
                w_ctrl.mi = 1'b1;
            end
            S_T1: begin
                w_ctrl.ro = 1'b1;
                w_ctrl.ii = 1'b1;
                w_ctrl.ce = 1'b1;
                w_last    = w_is_nop;
            end
            S_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        w_ctrl.io = 1'b1;
                        w_ctrl.mi = 1'b1;
                    end
                    OP_LDI: begin
                        w_ctrl.io = 1'b1;
                        w_ctrl.ai = 1'b1;
                        w_last    = 1'b1;
                    end
                    OP_JMP: begin
                        w_ctrl.io = 1'b1;
                        w_ctrl.j  = 1'b1;
                        w_last    = 1'b1;
                    end
                    // Conditional jumps: the operand is still driven so the bus
                    // is never floating; only the PC load is conditional.
                    OP_JC: begin
                        w_ctrl.io = 1'b1;
                        w_ctrl.j  = r_cf;
                        w_last    = 1'b1;
                    end
                    OP_JZ: begin
                        w_ctrl.io = 1'b1;
                        w_ctrl.j  = r_zf;
                        w_last    = 1'b1;
                    end
                    OP_OUT: begin
                        w_ctrl.ao = 1'b1;
                        w_ctrl.oi = 1'b1;
                        w_last    = 1'b1;
                    end
                    OP_HLT: begin
                        w_ctrl.hlt = 1'b1;
                        w_last     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T3: begin
                case (opcode)
                    OP_LDA: begin
                        w_ctrl.ro = 1'b1;
                        w_ctrl.ai = 1'b1;
                        w_last    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_ctrl.ro = 1'b1;
                        w_ctrl.bi = 1'b1;
                        w_ctrl.su = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        w_ctrl.ao = 1'b1;
                        w_ctrl.ri = 1'b1;
                        w_last    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    w_ctrl.eo = 1'b1;
                    w_ctrl.ai = 1'b1;
                    w_ctrl.fi = 1'b1;
                    w_ctrl.su = (opcode == OP_SUB);
                    w_last    = 1'b1;
                end
            end
            S_HALT: begin
                w_ctrl.hlt = 1'b1;
            end
            default: ;
        endcase

        if (r_state == S_HALT) begin
            w_state_next = S_HALT;
        end else if (r_state == S_T2 && opcode == OP_HLT) begin
            w_state_next = S_HALT;
        end else if (r_state == S_T4 || (EARLY_END && w_last)) begin
            w_state_next = S_T0;
        end else begin
            w_state_next = state_t'(r_state + 3'd1);
        end
    end

    // -------------------------------------------------------------------------
    // Flags register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_zf <= 1'b0;
            r_cf <= 1'b0;
        end else if (w_ctrl.fi) begin
            r_zf <= zf;
            r_cf <= cf;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Gating with rst makes every strobe drop the instant reset asserts, so an
    // interrupted STA/LDA cannot complete a partial write.
    assign w_out = rst ? w_ctrl : '0;

    assign co   = w_out.co;
    assign ce   = w_out.ce;
    assign j    = w_out.j;
    assign mi   = w_out.mi;
    assign ro   = w_out.ro;
    assign ri   = w_out.ri;
    assign ii   = w_out.ii;
    assign io   = w_out.io;
    assign ai   = w_out.ai;
    assign ao   = w_out.ao;
    assign bi   = w_out.bi;
    assign eo   = w_out.eo;
    assign su   = w_out.su;
    assign oi   = w_out.oi;
    assign fi   = w_out.fi;
    assign hlt  = w_out.hlt;

    assign step = (r_state == S_HALT) ? 3'd2 : 3'(r_state);
    assign zf_q = r_zf;
    assign cf_q = r_cf;

    // Only one source may drive the shared bus in any step.
    a_bus_single_driver : assert property (
        @(posedge clk) disable iff (!rst) $onehot0({co, ro, io, ao, eo})
    );

endmodule

// File: tb/tb_sap_control_unit.sv
// -----------------------------------------------------------------------------
// tb_sap_control_unit
//
// Two instances: dut_a with EARLY_END=1 and dut_b with EARLY_END=0. A driver
// walks instructions through each DUT one T-state at a time and pushes the
// expected control word, step and latched flags for that cycle into a queue;
// a per-DUT monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_sap_control_unit;

    localparam int CO = 15, CE = 14, J = 13, MI = 12, RO = 11, RI = 10, II = 9,
                   IO = 8, AI = 7, AO = 6, BI = 5, EO = 4, SU = 3, OI = 2,
                   FI = 1, HLT = 0;

    typedef struct packed {
        logic [15:0] w;
        logic [2:0]  st;
        logic        zq;
        logic        cq;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [3:0]  op_a, op_b;
    logic        zf_a, cf_a, zf_b, cf_b;
    logic [15:0] w_a, w_b;
    logic [2:0]  st_a, st_b;
    logic        zq_a, cq_a, zq_b, cq_b;

    exp_t q_a[$];
    exp_t q_b[$];
    logic mz[2];
    logic mc[2];

    int total = 0;
    int bad   = 0;

    sap_control_unit #(.EARLY_END(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .opcode(op_a), .zf(zf_a), .cf(cf_a),
        .co(w_a[CO]), .ce(w_a[CE]), .j(w_a[J]), .mi(w_a[MI]), .ro(w_a[RO]),
        .ri(w_a[RI]), .ii(w_a[II]), .io(w_a[IO]), .ai(w_a[AI]), .ao(w_a[AO]),
        .bi(w_a[BI]), .eo(w_a[EO]), .su(w_a[SU]), .oi(w_a[OI]), .fi(w_a[FI]),
        .hlt(w_a[HLT]), .step(st_a), .zf_q(zq_a), .cf_q(cq_a)
    );

    sap_control_unit #(.EARLY_END(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(op_b), .zf(zf_b), .cf(cf_b),
        .co(w_b[CO]), .ce(w_b[CE]), .j(w_b[J]), .mi(w_b[MI]), .ro(w_b[RO]),
        .ri(w_b[RI]), .ii(w_b[II]), .io(w_b[IO]), .ai(w_b[AI]), .ao(w_b[AO]),
        .bi(w_b[BI]), .eo(w_b[EO]), .su(w_b[SU]), .oi(w_b[OI]), .fi(w_b[FI]),
        .hlt(w_b[HLT]), .step(st_b), .zf_q(zq_b), .cf_q(cq_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] m(input int i);
        return 16'd1 << i;
    endfunction

    // Reference microcode, written directly from the instruction table.
    function automatic logic [15:0] exp_word(input logic [3:0] op, input int t,
                                             input logic zq, input logic cq);
        if (t == 0) return m(CO) | m(MI);
        if (t == 1) return m(RO) | m(II) | m(CE);
        case (op)
            4'h1: if (t == 2) return m(IO) | m(MI);
                  else if (t == 3) return m(RO) | m(AI);
            4'h2, 4'h3: begin
                if (t == 2) return m(IO) | m(MI);
                if (t == 3) return m(RO) | m(BI) | ((op == 4'h3) ? m(SU) : 16'd0);
                if (t == 4) return m(EO) | m(AI) | m(FI) | ((op == 4'h3) ? m(SU) : 16'd0);
            end
            4'h4: if (t == 2) return m(IO) | m(MI);
                  else if (t == 3) return m(AO) | m(RI);
            4'h5: if (t == 2) return m(IO) | m(AI);
            4'h6: if (t == 2) return m(IO) | m(J);
            4'h7: if (t == 2) return m(IO) | (cq ? m(J) : 16'd0);
            4'h8: if (t == 2) return m(IO) | (zq ? m(J) : 16'd0);
            4'hE: if (t == 2) return m(AO) | m(OI);
            4'hF: if (t == 2) return m(HLT);
            default: ;
        endcase
        return 16'd0;
    endfunction

    function automatic int last_step(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 3;
            4'h2, 4'h3: return 4;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic drive(input int sel, input logic [3:0] op, input logic z, input logic c);
        if (sel == 0) begin
            op_a = op; zf_a = z; cf_a = c;
        end else begin
            op_b = op; zf_b = z; cf_b = c;
        end
    endtask

    task automatic push(input int sel, input exp_t e);
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    // Reset is asserted now and held across one rising edge; the DUT outputs
    // are checked directly while reset is low.
    task automatic pulse_reset(input int sel);
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        #1;
        if (sel == 0) begin
            check("rst_a_word", 32'(w_a), 32'd0);
            check("rst_a_ri", 32'(w_a[RI]), 32'd0);
            check("rst_a_ao", 32'(w_a[AO]), 32'd0);
            check("rst_a_step", 32'(st_a), 32'd0);
            check("rst_a_flags", 32'({zq_a, cq_a}), 32'd0);
        end else begin
            check("rst_b_word", 32'(w_b), 32'd0);
            check("rst_b_step", 32'(st_b), 32'd0);
            check("rst_b_flags", 32'({zq_b, cq_b}), 32'd0);
        end
        mz[sel] = 1'b0;
        mc[sel] = 1'b0;
        @(posedge clk); #1;
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
    endtask

    // Entered and left just after a rising edge. force_t pins the ALU flags in
    // that step; abort_t asserts reset in the middle of that step.
    task automatic run_instr(input int sel, input logic [3:0] op,
                             input int force_t = -1, input logic fz = 1'b0,
                             input logic fc = 1'b0, input int abort_t = -1);
        int   n;
        exp_t e;
        logic z, c;
        n = (sel == 0 || op == 4'hF) ? last_step(op) + 1 : 5;
        for (int t = 0; t < n; t++) begin
            z = 1'($urandom);
            c = 1'($urandom);
            if (t == force_t) begin
                z = fz;
                c = fc;
            end
            drive(sel, op, z, c);
            e.w  = exp_word(op, t, mz[sel], mc[sel]);
            e.st = 3'(t);
            e.zq = mz[sel];
            e.cq = mc[sel];
            push(sel, e);
            if (e.w[FI]) begin
                mz[sel] = z;
                mc[sel] = c;
            end
            if (t == abort_t) begin
                @(negedge clk); #2;
                pulse_reset(sel);
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic halt_cycles(input int sel, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(sel, (i % 2 == 0) ? 4'h1 : 4'($urandom), 1'($urandom), 1'($urandom));
            e.w  = m(HLT);
            e.st = 3'd2;
            e.zq = mz[sel];
            e.cq = mc[sel];
            push(sel, e);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_word", 32'(w_a), 32'(e.w));
            check("a_step", 32'(st_a), 32'(e.st));
            check("a_flags", 32'({zq_a, cq_a}), 32'({e.zq, e.cq}));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b_word", 32'(w_b), 32'(e.w));
            check("b_step", 32'(st_b), 32'(e.st));
            check("b_flags", 32'({zq_b, cq_b}), 32'({e.zq, e.cq}));
        end
    end

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        drive(0, 4'h0, 1'b0, 1'b0);
        drive(1, 4'h0, 1'b0, 1'b0);
        mz = '{1'b0, 1'b0};
        mc = '{1'b0, 1'b0};
        #2;
        check("init_a_word", 32'(w_a), 32'd0);
        check("init_a_step", 32'(st_a), 32'd0);
        check("init_b_word", 32'(w_b), 32'd0);
        check("init_b_flags", 32'({zq_b, cq_b}), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b1;

        // NOP fetch-only loop: steps 0,1,0,1.
        run_instr(0, 4'h0);
        run_instr(0, 4'h0);

        // ADD latching zf=0, cf=1, then JC taken.
        run_instr(0, 4'h2, 4, 1'b0, 1'b1);
        run_instr(0, 4'h7);
        // SUB with carry, JC taken; ADD clearing carry, JC not taken, JZ taken.
        run_instr(0, 4'h3, 4, 1'b0, 1'b1);
        run_instr(0, 4'h7);
        run_instr(0, 4'h2, 4, 1'b1, 1'b0);
        run_instr(0, 4'h7);
        run_instr(0, 4'h8);

        // Reset in the middle of STA's T3 with both flags set.
        run_instr(0, 4'h2, 4, 1'b1, 1'b1);
        run_instr(0, 4'h4, -1, 1'b0, 1'b0, 3);
        run_instr(0, 4'h0);

        for (int i = 0; i < 60; i++) run_instr(0, 4'($urandom_range(0, 14)));

        // HLT, 20 frozen cycles, reset exit, then a clean fetch.
        run_instr(0, 4'hF);
        halt_cycles(0, 20);
        pulse_reset(0);
        run_instr(0, 4'h0);

        // Fixed-length sequencing on the EARLY_END=0 instance.
        rst_b = 1'b1;
        run_instr(1, 4'h5);
        run_instr(1, 4'h2, 4, 1'b1, 1'b0);
        run_instr(1, 4'h8);
        for (int i = 0; i < 30; i++) run_instr(1, 4'($urandom_range(0, 14)));
        run_instr(1, 4'hF);
        halt_cycles(1, 5);

        repeat (2) @(negedge clk);
        #1;
        check("drain_a", 32'(q_a.size()), 32'd0);
        check("drain_b", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
- Microcoded sequencer for the 8-bit SAP datapath: accumulator A, register B, ALU, RAM/MAR, program counter, instruction register (IR), output register.
- Runs a T-state step counter and decodes the IR opcode into the per-step control word that drives the shared 8-bit bus.
- Holds the flags register that latches the ALU zero/carry outputs, so that conditional jumps use stable flags.

Parameters:
- EARLY_END, 1: 1 = step counter returns to T0 after the last active step of each opcode; 0 = every instruction runs T0..T4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- opcode  in  4  IR[7:4], the current instruction opcode
- zf  in  1  ALU zero flag (combinational)
- cf  in  1  ALU carry flag (combinational)
- co  out  1  PC drives the bus
- ce  out  1  PC increment
- j  out  1  PC loads from the bus (jump)
- mi  out  1  MAR load
- ro  out  1  RAM drives the bus
- ri  out  1  RAM write
- ii  out  1  IR load
- io  out  1  IR operand nibble drives the bus
- ai  out  1  A load
- ao  out  1  A drives the bus
- bi  out  1  B load
- eo  out  1  ALU drives the bus
- su  out  1  ALU subtract select
- oi  out  1  output register load
- fi  out  1  flags register load
- hlt  out  1  halted; gates the clock enable of the rest of the CPU
- step  out  3  current T-state 0..4 (debug)
- zf_q  out  1  latched zero flag
- cf_q  out  1  latched carry flag

Behaviour:
- Reset (rst low, asynchronous): step=0, zf_q=0, cf_q=0, halted state cleared. While rst is low every control output is forced to 0.
- The control word is combinational from (step, opcode, zf_q, cf_q). step advances by +1 each rising edge.
- Common fetch steps:
  - T0: co, mi
  - T1: ro, ii, ce
- Per-opcode steps:
  - 0 NOP: no further steps; last step T1.
  - 1 LDA: T2 io,mi; T3 ro,ai; last T3.
  - 2 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi; last T4.
  - 3 SUB: as ADD, with su asserted in T3 and T4.
  - 4 STA: T2 io,mi; T3 ao,ri; last T3.
  - 5 LDI: T2 io,ai; last T2.
  - 6 JMP: T2 io,j; last T2.
  - 7 JC: T2 io, plus j only if cf_q=1; last T2.
  - 8 JZ: T2 io, plus j only if zf_q=1; last T2.
  - E OUT: T2 ao,oi; last T2.
  - F HLT: T2 hlt; enters HALTED.
  - 9-D: treated as NOP.
- Step wrap:
  - EARLY_END=1: at the rising edge ending an opcode's last step, step goes to 0.
  - EARLY_END=0: step goes 4 -> 0 always; unused steps output an all-zero word.
- Flags: at the rising edge where fi=1, zf_q<=zf and cf_q<=cf. Otherwise the flags hold. A conditional jump evaluates the flags as latched before its T2.
- HALTED: step freezes at 2; hlt=1 and all other outputs 0; opcode changes are ignored. Exit only through rst.
- Bus invariant: at most one of co, ro, io, ao, eo is high in any step. A violation is a design error and is checked by assertion.
- Reset mid-instruction: immediate return to T0 state; flags cleared; no partial writes (ri, ai etc. drop asynchronously).
- Latency:
  - EARLY_END=1: NOP 2, LDI/JMP/JC/JZ/OUT 3, LDA/STA 4, ADD/SUB 5 cycles.
  - EARLY_END=0: 5 cycles for every instruction.

Test Plan:
- Reset release, opcode=0, EARLY_END=1 -> step sequence 0,1,0,1; T0 word {co,mi}, T1 word {ro,ii,ce}; all other outputs 0.
- opcode=2 with zf=0, cf=1 during T4 -> T4 word {eo,ai,fi}; su=0 throughout; cf_q=1, zf_q=0 after the edge; step returns to 0.
- opcode=3, then opcode=7 with cf_q=1 -> su high in T3 and T4; JC T2 asserts {io,j}. Repeat with cf_q=0 -> T2 word {io} only.
- opcode=F -> hlt=1 from T2 onward; step stuck at 2 for 20 cycles despite opcode changing to 1; rst pulse low -> step=0, hlt=0.
- EARLY_END=0, opcode=5 -> T2 {io,ai}, T3 and T4 all-zero, then step 0; total 5 cycles.
- rst asserted mid-T3 of STA -> ri and ao drop within the same cycle (asynchronous); zf_q=cf_q=0; after release the T0 word is asserted. Bus-invariant assertion is active across all scenarios.
